risc_mgmt_arbiter: RTL and testbench
====================================

# risc_mgmt_arbiter

Parametrised RISC-MGMT dispatch and arbitration unit for the two-stage pipeline. It supports N_EXT extensions instead of one. Each instruction has exactly one owning extension, and the arbiter muxes that extension's register-write, data-memory and exception traffic onto the single core path. It generates the decode/execute hazard signals and enforces a stall watchdog so a hung extension cannot lock the core.

## Interface
Parameters:
- N_EXT, 4, number of extensions (>=1); OWN_W = max(1, $clog2(N_EXT))
- CAUSE_W, 4, per-extension exception cause width
- MAX_STALL, 255, watchdog limit in cycles (>=2)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; synchronous, active-low
- decode_valid  in  1  decode stage holds a valid instruction
- pipe_stall  in  1  core stalled; no new claim accepted
- flush  in  1  kill the in-flight extension instruction
- ext_claim  in  N_EXT  extension i decodes the current instruction
- ext_done  in  N_EXT  extension i finished execute
- ext_reg_w  in  N_EXT  write rd at commit
- ext_rsel_d  in  N_EXT*5  destination register
- ext_reg_wdata  in  N_EXT*32  write data
- ext_req_mem, ext_mem_ren, ext_mem_wen  in  N_EXT each  memory request/type
- ext_mem_addr, ext_mem_store  in  N_EXT*32 each  address/store data
- ext_exception  in  N_EXT  exception at commit
- ext_ex_cause  in  N_EXT*CAUSE_W  cause
- dmem_busy  in  1  core data bus busy
- dmem_load  in  32  load data
- dmem_ren, dmem_wen  out  1  bus strobes
- dmem_addr, dmem_store  out  32
- ext_mem_busy  out  N_EXT  per-extension busy
- ext_mem_load  out  32  dmem_load broadcast
- active_insn  out  1  extension instruction in flight
- owner  out  OWN_W  owning extension index
- decode_bubble, execute_stall  out  1  hazard controls
- reg_w  out  1; rsel_d  out  5; reg_wdata  out  32  commit write
- exception  out  1; ex_cause  out  OWN_W+CAUSE_W; timeout  out  1

## Operation
- FSM states are IDLE, EXEC, MEM, and FLUSH_WAIT. Reset puts it in IDLE with owner=0, watchdog=0, and every output 0.
- IDLE accept condition is decode_valid & |ext_claim & !pipe_stall. On accept, the lowest-index claimant wins, owner is latched, and the next state is EXEC. Other claimants are ignored.
- active_insn = (state != IDLE). decode_bubble and execute_stall = (state is EXEC, MEM or FLUSH_WAIT). In FLUSH_WAIT, execute_stall only.
- EXEC:
  - ext_done[owner] commits, with priority over req_mem, and the next state is IDLE.
  - Otherwise ext_req_mem[owner] moves to MEM.
- Commit produces registered one-cycle pulses:
  - reg_w = ext_reg_w[owner] & !ext_exception[owner], together with rsel_d and reg_wdata.
  - exception = ext_exception[owner], with ex_cause = {owner, ext_ex_cause[owner]}.
  - Exception suppresses reg_w.
- MEM:
  - dmem_ren/wen/addr/store are driven combinationally from the owner's request. Non-owners see ext_mem_busy=0.
  - ext_mem_busy[owner] = dmem_busy.
  - The first cycle with dmem_busy=0 completes the access: ext_mem_load is valid that cycle and the next state is EXEC.
  - The extension must drop req_mem in the completion cycle. A req_mem still high in the following EXEC cycle starts a new access.
- Watchdog:
  - Counts every cycle in EXEC/MEM and clears on IDLE entry.
  - Reaching MAX_STALL in EXEC pulses exception and timeout, with ex_cause = {owner, all-ones}, and goes to IDLE.
  - In MEM, the timeout waits for dmem_busy=0 and then fires.
- Flush:
  - In EXEC, flush goes to IDLE with no commit pulses.
  - In MEM with dmem_busy=1, go to FLUSH_WAIT. Strobes stay held until busy falls, then go to IDLE with no commit.
  - A flush in IDLE blocks acceptance that cycle.
- Simultaneous flush and ext_done: flush wins.
- nRST low in any state: IDLE next edge, with strobes and pulses deasserted.

## Timing
- Accept edge t, then EXEC from t+1. Done sampled at edge t+k produces commit pulses during cycle t+k+1, and the FSM is back in IDLE that same cycle. Minimum instruction span is 2 cycles.
- A new accept is allowed in the commit-pulse cycle, giving back-to-back occupancy.
- A memory access costs a MEM entry cycle plus dmem_busy cycles. The return to EXEC adds 1 cycle.
- Hazard outputs are combinational from state. Commit/exception outputs are registered.

## Test plan
- N_EXT=4, claim=4'b0110 in IDLE -> owner=1. ext_done[1] with reg_w, rsel_d=5, wdata=0xDEADBEEF -> reg_w pulses one cycle, rsel_d=5, reg_wdata=0xDEADBEEF.
- Owner 2 load at addr 0x100, dmem_busy high for 3 cycles, then dmem_load=0x1234 -> dmem_ren held 4 cycles, ext_mem_busy=4'b0100 for 3 cycles, owner sees 0x1234 in the completion cycle.
- ext_exception[3] with cause 4'h5 and reg_w=1 -> exception=1, ex_cause=6'b11_0101, reg_w stays 0.
- Owner never asserts done, MAX_STALL=8 -> timeout and exception pulse 8 cycles after EXEC entry, ex_cause={owner,4'hF}, FSM in IDLE.
- Flush during MEM with dmem_busy=1 for 2 cycles -> strobes held until busy low, then IDLE, no reg_w/exception.
- nRST low mid-EXEC for one edge -> all outputs 0 and active_insn=0 next cycle. A fresh claim is accepted normally after release.

Source files
------------

// File: rtl/risc_mgmt_arbiter_if.sv
// Bundle between the RISC-MGMT arbiter, the core pipeline and the N_EXT extensions.
// master is the arbiter's view; slave is the core/extension side.
interface risc_mgmt_arbiter_if #(
  parameter int N_EXT   = 4,
  parameter int CAUSE_W = 4
);
  localparam int OWN_W = (N_EXT > 1) ? $clog2(N_EXT) : 1;

  logic                       decode_valid;
  logic                       pipe_stall;
  logic                       flush;
  logic [N_EXT-1:0]           ext_claim;
  logic [N_EXT-1:0]           ext_done;
  logic [N_EXT-1:0]           ext_reg_w;
  logic [N_EXT*5-1:0]         ext_rsel_d;
  logic [N_EXT*32-1:0]        ext_reg_wdata;
  logic [N_EXT-1:0]           ext_req_mem;
  logic [N_EXT-1:0]           ext_mem_ren;
  logic [N_EXT-1:0]           ext_mem_wen;
  logic [N_EXT*32-1:0]        ext_mem_addr;
  logic [N_EXT*32-1:0]        ext_mem_store;
  logic [N_EXT-1:0]           ext_exception;
  logic [N_EXT*CAUSE_W-1:0]   ext_ex_cause;
  logic                       dmem_busy;
  logic [31:0]                dmem_load;

  logic                       dmem_ren;
  logic                       dmem_wen;
  logic [31:0]                dmem_addr;
  logic [31:0]                dmem_store;
  logic [N_EXT-1:0]           ext_mem_busy;
  logic [31:0]                ext_mem_load;
  logic                       active_insn;
  logic [OWN_W-1:0]           owner;
  logic                       decode_bubble;
  logic                       execute_stall;
  logic                       reg_w;
  logic [4:0]                 rsel_d;
  logic [31:0]                reg_wdata;
  logic                       exception;
  logic [OWN_W+CAUSE_W-1:0]   ex_cause;
  logic                       timeout;

  modport master (
    input  decode_valid, pipe_stall, flush, ext_claim, ext_done, ext_reg_w,
           ext_rsel_d, ext_reg_wdata, ext_req_mem, ext_mem_ren, ext_mem_wen,
           ext_mem_addr, ext_mem_store, ext_exception, ext_ex_cause,
           dmem_busy, dmem_load,
    output dmem_ren, dmem_wen, dmem_addr, dmem_store, ext_mem_busy, ext_mem_load,
           active_insn, owner, decode_bubble, execute_stall, reg_w, rsel_d,
           reg_wdata, exception, ex_cause, timeout
  );

  modport slave (
    output decode_valid, pipe_stall, flush, ext_claim, ext_done, ext_reg_w,
           ext_rsel_d, ext_reg_wdata, ext_req_mem, ext_mem_ren, ext_mem_wen,
           ext_mem_addr, ext_mem_store, ext_exception, ext_ex_cause,
           dmem_busy, dmem_load,
    input  dmem_ren, dmem_wen, dmem_addr, dmem_store, ext_mem_busy, ext_mem_load,
           active_insn, owner, decode_bubble, execute_stall, reg_w, rsel_d,
           reg_wdata, exception, ex_cause, timeout
  );
endinterface

// File: rtl/risc_mgmt_arbiter.sv
// RISC-MGMT dispatch/arbitration: one owning extension per instruction, its traffic muxed
// onto the core path, hazard generation and a stall watchdog against hung extensions.
module risc_mgmt_arbiter #(
  parameter int N_EXT     = 4,
  parameter int CAUSE_W   = 4,
  parameter int MAX_STALL = 255
) (
  input  logic                 CLK,
  input  logic                 nRST,
  risc_mgmt_arbiter_if.master  bus
);

  localparam int OWN_W = (N_EXT > 1) ? $clog2(N_EXT) : 1;
  localparam int WD_W  = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, FLUSH_WAIT} state_t;

  state_t            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              sel_done, sel_req, sel_ren, sel_wen, sel_regw, sel_exc;
  logic [4:0]        sel_rsel;
  logic [31:0]       sel_wdata, sel_addr, sel_store;
  logic [CAUSE_W-1:0] sel_cause;

  logic              regw_d, exc_d, tmo_d, fw_load;
  logic [CAUSE_W-1:0] cause_d;

  logic              reg_w_vld_p1, exc_vld_p1, tmo_vld_p1;
  logic [4:0]        rsel_p1;
  logic [31:0]       wdata_p1;
  logic [OWN_W+CAUSE_W-1:0] cause_p1;

  logic              fw_ren, fw_wen;
  logic [31:0]       fw_addr, fw_store;
  logic [N_EXT-1:0]  mem_busy;

  function automatic logic [OWN_W-1:0] first_claim(input logic [N_EXT-1:0] c);
    logic [OWN_W-1:0] idx;
    idx = '0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (c[i]) idx = OWN_W'(i);
    end
    return idx;
  endfunction

  // Saturates so a long memory wait cannot wrap the watchdog back below the limit.
  function automatic logic [WD_W-1:0] wd_inc(input logic [WD_W-1:0] v);
    return (v >= WD_W'(MAX_STALL)) ? v : v + 1'b1;
  endfunction

  always_comb begin
    sel_done  = 1'b0;
    sel_req   = 1'b0;
    sel_ren   = 1'b0;
    sel_wen   = 1'b0;
    sel_regw  = 1'b0;
    sel_exc   = 1'b0;
    sel_rsel  = '0;
    sel_wdata = '0;
    sel_addr  = '0;
    sel_store = '0;
    sel_cause = '0;
    for (int i = 0; i < N_EXT; i++) begin
      if (owner_q == OWN_W'(i)) begin
        sel_done  = bus.ext_done[i];
        sel_req   = bus.ext_req_mem[i];
        sel_ren   = bus.ext_mem_ren[i];
        sel_wen   = bus.ext_mem_wen[i];
        sel_regw  = bus.ext_reg_w[i];
        sel_exc   = bus.ext_exception[i];
        sel_rsel  = bus.ext_rsel_d[i*5 +: 5];
        sel_wdata = bus.ext_reg_wdata[i*32 +: 32];
        sel_addr  = bus.ext_mem_addr[i*32 +: 32];
        sel_store = bus.ext_mem_store[i*32 +: 32];
        sel_cause = bus.ext_ex_cause[i*CAUSE_W +: CAUSE_W];
      end
    end
  end

  // Priority inside an instruction: flush, then done, then watchdog, then memory request.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    regw_d  = 1'b0;
    exc_d   = 1'b0;
    tmo_d   = 1'b0;
    cause_d = sel_cause;
    fw_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.decode_valid && (|bus.ext_claim) && !bus.pipe_stall && !bus.flush) begin
          state_d = EXEC;
          owner_d = first_claim(bus.ext_claim);
        end
      end
      EXEC: begin
        wd_d = wd_inc(wd_q);
        if (bus.flush) begin
          state_d = IDLE;
        end else if (sel_done) begin
          state_d = IDLE;
          regw_d  = sel_regw && !sel_exc;
          exc_d   = sel_exc;
        end else if (wd_q >= WD_LIMIT) begin
          state_d = IDLE;
          exc_d   = 1'b1;
          tmo_d   = 1'b1;
          cause_d = '1;
        end else if (sel_req) begin
          state_d = MEM;
        end
      end
      MEM: begin
        wd_d = wd_inc(wd_q);
        if (bus.flush) begin
          if (bus.dmem_busy) begin
            state_d = FLUSH_WAIT;
            fw_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.dmem_busy) begin
          if (wd_q >= WD_LIMIT) begin
            state_d = IDLE;
            exc_d   = 1'b1;
            tmo_d   = 1'b1;
            cause_d = '1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      FLUSH_WAIT: begin
        if (!bus.dmem_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) wd_d = '0;
  end

  // Stage p1: registered commit/exception pulses
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      wd_q         <= '0;
      reg_w_vld_p1 <= 1'b0;
      exc_vld_p1   <= 1'b0;
      tmo_vld_p1   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wd_q         <= wd_d;
      reg_w_vld_p1 <= regw_d;
      exc_vld_p1   <= exc_d;
      tmo_vld_p1   <= tmo_d;
    end
  end

  always_ff @(posedge CLK) begin
    rsel_p1  <= sel_rsel;
    wdata_p1 <= sel_wdata;
    cause_p1 <= {owner_q, cause_d};
    if (fw_load) begin
      fw_ren   <= sel_ren;
      fw_wen   <= sel_wen;
      fw_addr  <= sel_addr;
      fw_store <= sel_store;
    end
  end

  always_comb begin
    mem_busy = '0;
    for (int i = 0; i < N_EXT; i++) begin
      mem_busy[i] = (state_q == MEM) && (owner_q == OWN_W'(i)) && bus.dmem_busy;
    end
  end

  // A flushed access keeps its captured strobes on the bus until the slave lets go.
  assign bus.dmem_ren   = (state_q == MEM) ? sel_ren   : (state_q == FLUSH_WAIT) ? fw_ren   : 1'b0;
  assign bus.dmem_wen   = (state_q == MEM) ? sel_wen   : (state_q == FLUSH_WAIT) ? fw_wen   : 1'b0;
  assign bus.dmem_addr  = (state_q == MEM) ? sel_addr  : (state_q == FLUSH_WAIT) ? fw_addr  : 32'd0;
  assign bus.dmem_store = (state_q == MEM) ? sel_store : (state_q == FLUSH_WAIT) ? fw_store : 32'd0;

  assign bus.ext_mem_busy  = mem_busy;
  assign bus.ext_mem_load  = bus.dmem_load;
  assign bus.active_insn   = (state_q != IDLE);
  assign bus.owner         = owner_q;
  assign bus.decode_bubble = (state_q == EXEC) || (state_q == MEM);
  assign bus.execute_stall = (state_q != IDLE);

  assign bus.reg_w     = reg_w_vld_p1;
  assign bus.rsel_d    = reg_w_vld_p1 ? rsel_p1  : 5'd0;
  assign bus.reg_wdata = reg_w_vld_p1 ? wdata_p1 : 32'd0;
  assign bus.exception = exc_vld_p1;
  assign bus.ex_cause  = exc_vld_p1 ? cause_p1 : '0;
  assign bus.timeout   = tmo_vld_p1;

endmodule

// File: tb/tb_risc_mgmt_arbiter.sv
// Bench for risc_mgmt_arbiter: directed scenarios plus random traffic against a
// flag-based behavioural model of the dispatch/commit rules.
module tb_risc_mgmt_arbiter;
  localparam int NE    = 4;
  localparam int CW    = 4;
  localparam int MAXS  = 8;

  logic clk;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;

  risc_mgmt_arbiter_if #(.N_EXT(NE), .CAUSE_W(CW)) bus ();

  risc_mgmt_arbiter #(.N_EXT(NE), .CAUSE_W(CW), .MAX_STALL(MAXS)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL sim_timeout: bench did not finish in time");
    $fatal(1, "bench time limit expired");
  end

  // Reference model: instruction in flight, in a memory access, or draining a flushed access.
  bit          m_act, m_mem, m_fw;
  int          m_own, m_spent;
  logic        e_regw, e_exc, e_tmo;
  logic [4:0]  e_rsel;
  logic [31:0] e_wdata;
  logic [5:0]  e_cause;
  logic        f_ren, f_wen;
  logic [31:0] f_addr, f_store;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.decode_valid  = 1'b0;
    bus.pipe_stall    = 1'b0;
    bus.flush         = 1'b0;
    bus.ext_claim     = '0;
    bus.ext_done      = '0;
    bus.ext_reg_w     = '0;
    bus.ext_rsel_d    = '0;
    bus.ext_reg_wdata = '0;
    bus.ext_req_mem   = '0;
    bus.ext_mem_ren   = '0;
    bus.ext_mem_wen   = '0;
    bus.ext_mem_addr  = '0;
    bus.ext_mem_store = '0;
    bus.ext_exception = '0;
    bus.ext_ex_cause  = '0;
    bus.dmem_busy     = 1'b0;
    bus.dmem_load     = '0;
  endtask

  function automatic logic [NE-1:0] rbits(input int pct);
    logic [NE-1:0] v;
    for (int i = 0; i < NE; i++) v[i] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  task automatic model_check();
    logic        x_ren, x_wen;
    logic [31:0] x_addr, x_store;
    logic [NE-1:0] x_busy;
    x_ren = 1'b0; x_wen = 1'b0; x_addr = '0; x_store = '0; x_busy = '0;
    if (m_mem) begin
      x_ren   = bus.ext_mem_ren[m_own];
      x_wen   = bus.ext_mem_wen[m_own];
      x_addr  = bus.ext_mem_addr[m_own*32 +: 32];
      x_store = bus.ext_mem_store[m_own*32 +: 32];
      x_busy[m_own] = bus.dmem_busy;
    end else if (m_fw) begin
      x_ren = f_ren; x_wen = f_wen; x_addr = f_addr; x_store = f_store;
    end
    chk("active_insn", bus.active_insn, m_act);
    chk("owner", bus.owner, m_own);
    chk("decode_bubble", bus.decode_bubble, m_act && !m_fw);
    chk("execute_stall", bus.execute_stall, m_act);
    chk("dmem_ren", bus.dmem_ren, x_ren);
    chk("dmem_wen", bus.dmem_wen, x_wen);
    chk("dmem_addr", bus.dmem_addr, x_addr);
    chk("dmem_store", bus.dmem_store, x_store);
    chk("ext_mem_busy", bus.ext_mem_busy, x_busy);
    chk("ext_mem_load", bus.ext_mem_load, bus.dmem_load);
    chk("reg_w", bus.reg_w, e_regw);
    chk("rsel_d", bus.rsel_d, e_rsel);
    chk("reg_wdata", bus.reg_wdata, e_wdata);
    chk("exception", bus.exception, e_exc);
    chk("ex_cause", bus.ex_cause, e_cause);
    chk("timeout", bus.timeout, e_tmo);
  endtask

  task automatic model_edge();
    bit found, finish;
    int spent_now;
    e_regw = 1'b0; e_exc = 1'b0; e_tmo = 1'b0;
    e_rsel = '0; e_wdata = '0; e_cause = '0;
    if (!nrst) begin
      m_act = 0; m_mem = 0; m_fw = 0; m_own = 0; m_spent = 0;
      return;
    end
    if (!m_act) begin
      if (bus.decode_valid && bus.ext_claim != 0 && !bus.pipe_stall && !bus.flush) begin
        found = 0;
        for (int i = 0; i < NE; i++) begin
          if (!found && bus.ext_claim[i]) begin m_own = i; found = 1; end
        end
        m_act = 1; m_spent = 0;
      end
    end else if (m_fw) begin
      if (!bus.dmem_busy) begin m_act = 0; m_fw = 0; end
    end else begin
      spent_now = m_spent + 1;
      finish = 0;
      if (!m_mem) begin
        if (bus.flush) finish = 1;
        else if (bus.ext_done[m_own]) begin
          finish  = 1;
          e_exc   = bus.ext_exception[m_own];
          e_regw  = bus.ext_reg_w[m_own] && !e_exc;
          e_rsel  = e_regw ? bus.ext_rsel_d[m_own*5 +: 5] : 5'd0;
          e_wdata = e_regw ? bus.ext_reg_wdata[m_own*32 +: 32] : 32'd0;
          e_cause = e_exc ? 6'((m_own << CW) | int'(bus.ext_ex_cause[m_own*CW +: CW])) : 6'd0;
        end else if (spent_now >= MAXS) begin
          finish = 1; e_exc = 1; e_tmo = 1; e_cause = 6'((m_own << CW) | 15);
        end else if (bus.ext_req_mem[m_own]) m_mem = 1;
      end else begin
        if (bus.flush) begin
          if (bus.dmem_busy) begin
            m_fw = 1; m_mem = 0;
            f_ren   = bus.ext_mem_ren[m_own];
            f_wen   = bus.ext_mem_wen[m_own];
            f_addr  = bus.ext_mem_addr[m_own*32 +: 32];
            f_store = bus.ext_mem_store[m_own*32 +: 32];
          end else finish = 1;
        end else if (!bus.dmem_busy) begin
          if (spent_now >= MAXS) begin
            finish = 1; e_exc = 1; e_tmo = 1; e_cause = 6'((m_own << CW) | 15);
          end else m_mem = 0;
        end
      end
      m_spent = spent_now;
      if (finish) begin m_act = 0; m_mem = 0; m_spent = 0; end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    nrst = 1'b0;
    clear_inputs();
    m_act = 0; m_mem = 0; m_fw = 0; m_own = 0; m_spent = 0;
    e_regw = 0; e_exc = 0; e_tmo = 0; e_rsel = 0; e_wdata = 0; e_cause = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", bus.active_insn, 1'b0);
    chk("rst_owner", bus.owner, 2'd0);
    chk("rst_bubble", bus.decode_bubble, 1'b0);
    chk("rst_stall", bus.execute_stall, 1'b0);
    chk("rst_reg_w", bus.reg_w, 1'b0);
    chk("rst_exc", bus.exception, 1'b0);
    chk("rst_tmo", bus.timeout, 1'b0);
    chk("rst_ren", bus.dmem_ren, 1'b0);
    chk("rst_mem_busy", bus.ext_mem_busy, 4'd0);
    nrst = 1'b1;

    // Lowest claimant wins, commit write
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0110;
    step();
    chk("own_lowest", bus.owner, 2'd1);
    chk("accept_active", bus.active_insn, 1'b1);
    clear_inputs();
    bus.ext_done[1] = 1'b1; bus.ext_reg_w[1] = 1'b1;
    bus.ext_rsel_d[9:5] = 5'd5; bus.ext_reg_wdata[63:32] = 32'hDEADBEEF;
    step();
    chk("commit_reg_w", bus.reg_w, 1'b1);
    chk("commit_rsel", bus.rsel_d, 5'd5);
    chk("commit_wdata", bus.reg_wdata, 32'hDEADBEEF);
    chk("commit_idle", bus.active_insn, 1'b0);
    clear_inputs();
    step();
    chk("commit_pulse_end", bus.reg_w, 1'b0);

    // Owner 2 load with three busy cycles
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0100;
    step();
    clear_inputs();
    bus.ext_req_mem[2] = 1'b1; bus.ext_mem_ren[2] = 1'b1; bus.ext_mem_addr[95:64] = 32'h100;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.dmem_busy = 1'b1;
      #1;
      chk("ld_busy", bus.ext_mem_busy, 4'b0100);
      chk("ld_ren", bus.dmem_ren, 1'b1);
      chk("ld_addr", bus.dmem_addr, 32'h100);
      step();
    end
    bus.dmem_busy = 1'b0; bus.dmem_load = 32'h1234; bus.ext_req_mem[2] = 1'b0;
    #1;
    chk("ld_done_ren", bus.dmem_ren, 1'b1);
    chk("ld_done_busy", bus.ext_mem_busy, 4'd0);
    chk("ld_data", bus.ext_mem_load, 32'h1234);
    step();
    clear_inputs();
    bus.ext_done[2] = 1'b1;
    #1;
    chk("ld_back_exec", bus.dmem_ren, 1'b0);
    step();
    clear_inputs();

    // Exception suppresses the write
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b1000;
    step();
    clear_inputs();
    bus.ext_done[3] = 1'b1; bus.ext_exception[3] = 1'b1; bus.ext_reg_w[3] = 1'b1;
    bus.ext_ex_cause[15:12] = 4'h5;
    step();
    chk("exc_pulse", bus.exception, 1'b1);
    chk("exc_cause", bus.ex_cause, 6'b11_0101);
    chk("exc_no_reg_w", bus.reg_w, 1'b0);
    clear_inputs();
    step();

    // Watchdog
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0001;
    step();
    clear_inputs();
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.timeout && n < 20);
    chk("tmo_latency", n, 8);
    chk("tmo_exc", bus.exception, 1'b1);
    chk("tmo_cause", bus.ex_cause, 6'h0F);
    chk("tmo_idle", bus.active_insn, 1'b0);
    step();

    // Flush during a busy store
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0010;
    step();
    clear_inputs();
    bus.ext_req_mem[1] = 1'b1; bus.ext_mem_wen[1] = 1'b1;
    bus.ext_mem_addr[63:32] = 32'h200; bus.ext_mem_store[63:32] = 32'hCAFE0001;
    step();
    bus.dmem_busy = 1'b1; bus.flush = 1'b1;
    #1;
    chk("fl_wen_mem", bus.dmem_wen, 1'b1);
    step();
    clear_inputs();
    bus.dmem_busy = 1'b1;
    #1;
    chk("fl_wen_held", bus.dmem_wen, 1'b1);
    chk("fl_addr_held", bus.dmem_addr, 32'h200);
    chk("fl_store_held", bus.dmem_store, 32'hCAFE0001);
    chk("fl_bubble", bus.decode_bubble, 1'b0);
    chk("fl_stall", bus.execute_stall, 1'b1);
    step();
    bus.dmem_busy = 1'b0;
    #1;
    chk("fl_wen_last", bus.dmem_wen, 1'b1);
    step();
    chk("fl_idle", bus.active_insn, 1'b0);
    chk("fl_no_reg_w", bus.reg_w, 1'b0);
    chk("fl_no_exc", bus.exception, 1'b0);

    // Flush or stall in IDLE blocks acceptance; flush beats done
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0001; bus.flush = 1'b1;
    step();
    chk("idle_flush_block", bus.active_insn, 1'b0);
    bus.flush = 1'b0; bus.pipe_stall = 1'b1;
    step();
    chk("idle_stall_block", bus.active_insn, 1'b0);
    bus.pipe_stall = 1'b0;
    step();
    clear_inputs();
    bus.ext_done[0] = 1'b1; bus.ext_reg_w[0] = 1'b1; bus.flush = 1'b1;
    step();
    chk("flush_beats_done", bus.reg_w, 1'b0);
    chk("flush_done_idle", bus.active_insn, 1'b0);
    clear_inputs();

    // Reset mid-EXEC
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0001;
    step();
    clear_inputs();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    chk("rst_mid_active", bus.active_insn, 1'b0);
    chk("rst_mid_owner", bus.owner, 2'd0);
    chk("rst_mid_stall", bus.execute_stall, 1'b0);
    bus.decode_valid = 1'b1; bus.ext_claim = 4'b0100;
    step();
    chk("rst_reaccept", bus.active_insn, 1'b1);
    chk("rst_reaccept_own", bus.owner, 2'd2);
    clear_inputs();
    bus.ext_done[2] = 1'b1;
    step();
    clear_inputs();

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nrst              = ($urandom_range(0, 199) != 0);
      bus.decode_valid  = ($urandom_range(0, 99) < 70);
      bus.pipe_stall    = ($urandom_range(0, 99) < 15);
      bus.flush         = ($urandom_range(0, 99) < 5);
      bus.ext_claim     = rbits(40);
      bus.ext_done      = rbits(15);
      bus.ext_reg_w     = rbits(60);
      bus.ext_rsel_d    = 20'($urandom);
      bus.ext_reg_wdata = {$urandom, $urandom, $urandom, $urandom};
      bus.ext_req_mem   = rbits(30);
      bus.ext_mem_ren   = rbits(50);
      bus.ext_mem_wen   = rbits(50);
      bus.ext_mem_addr  = {$urandom, $urandom, $urandom, $urandom};
      bus.ext_mem_store = {$urandom, $urandom, $urandom, $urandom};
      bus.ext_exception = rbits(10);
      bus.ext_ex_cause  = 16'($urandom);
      bus.dmem_busy     = ($urandom_range(0, 99) < 50);
      bus.dmem_load     = $urandom;
      step();
    end
    nrst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
